jt12_ring_wr_sched: RTL
=======================

JT12_RING_WR_SCHED -- requirements
Module: jt12_ring_wr_sched

Interface
REQ-001 SHALL have parameter SLOTS, default 24: number of time-multiplexed slots circulating in the external shift ring (ring stages = SLOTS).
REQ-002 SHALL have parameter DW, default 8: width of one slot value.
REQ-003 SHALL have parameter DEPTH, default 4: pending-write FIFO depth, power of two, >= 2.
REQ-004 SHALL have port clk  in  1  clock.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port clk_en  in  1  ring advance enable; all state other than the FIFO push side advances only when it is high.
REQ-007 SHALL have port wr_valid  in  1  write request.
REQ-008 SHALL have port wr_ready  out  1  FIFO can accept a write.
REQ-009 SHALL have port wr_slot  in  5  target slot index.
REQ-010 SHALL have port wr_data  in  DW  value to load into the target slot.
REQ-011 SHALL have port ring_out  in  DW  value leaving the ring (ring drop).
REQ-012 SHALL have port ring_in  out  DW  value fed to the ring din.
REQ-013 SHALL have port slot  out  5  index of the slot currently presented on ring_out.
REQ-014 SHALL have port frame  out  1  high while slot == 0.
REQ-015 SHALL have port rd_req  in  1  read request; rd_slot sampled with it.
REQ-016 SHALL have port rd_slot  in  5  slot to read.
REQ-017 SHALL have port rd_valid  out  1  one-clk pulse, rd_data valid.
REQ-018 SHALL have port rd_data  out  DW  captured slot value.
REQ-019 SHALL have port pending  out  log2(DEPTH)+1  FIFO occupancy.
REQ-020 SHALL have port err  out  1  sticky: a write or read to slot >= SLOTS occurred.

Function
REQ-021 SHALL hold slot counter slot, incremented on each clk_en, wrapping SLOTS-1 -> 0.
REQ-022 SHALL drive ring_in = FIFO head data when hit, else ring_out (recirculate); hit = FIFO non-empty AND head slot == slot (combinational).
REQ-023 SHALL pop the FIFO head on a clk edge where hit AND clk_en; at most one pop per clk_en.
REQ-024 SHALL drive wr_ready = (pending < DEPTH), from registered occupancy; a pop in the same cycle does not raise wr_ready.
REQ-025 SHALL push {wr_slot, wr_data} on any clk edge with wr_valid AND wr_ready, independent of clk_en.
REQ-026 SHALL discard an accepted write with wr_slot >= SLOTS (no push, pending unchanged) and set err.
REQ-027 SHALL apply writes strictly in acceptance order; a head waiting for its slot blocks later entries (max wait SLOTS clk_en).
REQ-028 SHALL treat simultaneous push and pop as occupancy unchanged; pointers wrap modulo DEPTH.
REQ-029 SHALL latch a read request (one outstanding); further rd_req while outstanding is ignored.
REQ-030 SHALL, on the first clk_en edge with slot == latched rd_slot, capture ring_in into rd_data and pulse rd_valid for one clk; a same-cycle write to that slot returns the new value.
REQ-031 SHALL set err and not latch on rd_req with rd_slot >= SLOTS.
REQ-032 SHALL ignore wr_valid/rd_req for ring timing; with clk_en low, slot, ring_in mux and read capture hold.

Reset
REQ-033 SHALL on rst force: slot=0, FIFO empty, pending=0, wr_ready=1, rd_valid=0, rd_data=0, read outstanding cleared, err=0.
REQ-034 SHALL on rst mid-operation drop all queued writes and the outstanding read; none is applied after release.

Verification
REQ-035 SHALL cover: clk_en=1 continuous, write slot 5 data 0xA5 accepted while slot=2 -> ring_in=0xA5 at slot=5 (3 clk_en later), pending 1->0; ring_out=0xA5 24 clk_en after.
REQ-036 SHALL cover: 4 writes (slots 3,1,3,7) with no pops -> wr_ready=0, 5th write not accepted; entries applied in order 3,1 (next frame),3,7.
REQ-037 SHALL cover: write slot 24 -> err=1, pending stays 0, ring unchanged.
REQ-038 SHALL cover: rd_req slot 10 while ring holds 0x3C there -> rd_valid one clk at slot=10, rd_data=0x3C; with queued write 0x77 to slot 10 -> rd_data=0x77.
REQ-039 SHALL cover: clk_en toggled 1-in-6 -> slot and pops advance only on enabled edges; push accepted on disabled edges.
REQ-040 SHALL cover: rst asserted with pending=3 -> pending=0, slot=0, wr_ready=1 immediately; no queued value appears on ring_in.

Source files
------------

// File: rtl/jt12_ring_wr_sched.sv
// Write scheduler for a time-multiplexed shift ring: queues slot writes and
// splices each one into the ring when its slot comes around; also snoops one slot on request.
module jt12_ring_wr_sched #(
  parameter int SLOTS = 24,
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_en,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [4:0]               wr_slot,
  input  logic [DW-1:0]            wr_data,
  input  logic [DW-1:0]            ring_out,
  output logic [DW-1:0]            ring_in,
  output logic [4:0]               slot,
  output logic                     frame,
  input  logic                     rd_req,
  input  logic [4:0]               rd_slot,
  output logic                     rd_valid,
  output logic [DW-1:0]            rd_data,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [4:0]  LAST_SLOT = 5'(SLOTS - 1);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);

  logic [4:0]    fifo_slot [DEPTH];
  logic [DW-1:0] fifo_data [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic          rd_pend;
  logic [4:0]    rd_slot_q;

  logic          wr_bad;
  logic          rd_bad;
  logic          accept;
  logic          push;
  logic          hit;
  logic          pop;

  assign wr_ready = (count < FULL_CNT);
  assign wr_bad   = (wr_slot > LAST_SLOT);
  assign rd_bad   = (rd_slot > LAST_SLOT);
  assign accept   = wr_valid & wr_ready;
  assign push     = accept & ~wr_bad;

  // The head entry waits until its slot is on the ring drop, then replaces the recirculated value.
  assign hit      = (count != '0) && (fifo_slot[rd_ptr] == slot);
  assign ring_in  = hit ? fifo_data[rd_ptr] : ring_out;
  assign pop      = hit & clk_en;

  assign frame    = (slot == 5'd0);
  assign pending  = count;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_slot[wr_ptr] <= wr_slot;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      slot      <= '0;
      rd_pend   <= 1'b0;
      rd_slot_q <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      err       <= 1'b0;
    end else begin
      rd_valid <= 1'b0;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (clk_en) begin
        slot <= (slot == LAST_SLOT) ? 5'd0 : slot + 5'd1;
        // Capture what is fed back into the ring, so a write landing this cycle is seen.
        if (rd_pend && (slot == rd_slot_q)) begin
          rd_valid <= 1'b1;
          rd_data  <= ring_in;
          rd_pend  <= 1'b0;
        end
      end

      if (rd_req && !rd_pend && !rd_bad) begin
        rd_pend   <= 1'b1;
        rd_slot_q <= rd_slot;
      end

      if ((accept && wr_bad) || (rd_req && rd_bad)) err <= 1'b1;
    end
  end

endmodule
